// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the polyphase FIR sequencer.
// Phase count, tap geometry, pipeline latencies, FSM states.
package fir_seq_pkg;

  localparam int PHASES  = 8;
  localparam int PH_W    = $clog2(PHASES);
  localparam int ADDR_W  = 8;
  localparam int TAPS    = 2 ** ADDR_W;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [PHASES-1:0] phase_onehot(
    input logic [PH_W-1:0] p
  );
    logic [PHASES-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fir_seq_strobe_delay.sv
// Parameterised strobe shift register with async active-low reset.
// Aligns control strobes to ROM/RAM read and MAC pipeline latency.
module fir_seq_strobe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr[i] <= '0;
      end
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fir_phase_sequencer.sv
// Control sequencer for the 8-phase decimating polyphase FIR.
// Steers samples into phase RAMs and sweeps the shared tap address.
module fir_phase_sequencer
  import fir_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              x_avail,
  output logic [PHASES-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              y_avail,
  output logic              busy,
  output logic              overrun
);

  localparam int DRAIN_N = RD_LAT + MAC_LAT;
  localparam int DC_W    = $clog2(DRAIN_N + 1);

  state_t            state;
  state_t            state_d;
  logic [PH_W-1:0]   phase;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_pend;
  logic [ADDR_W-1:0] k;
  logic [DC_W-1:0]   dcnt;
  logic              pending;
  logic              trigger;
  logic              drain_end;
  logic              start;
  logic              run_v;
  logic              first_tap;
  logic              last_tap;

  assign trigger = x_avail &&
                   (phase == PH_W'(PHASES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_we      <= '0;
      ram_wr_addr <= '0;
      phase       <= '0;
      wr_ptr      <= '0;
    end else begin
      ram_we <= '0;
      if (x_avail) begin
        ram_we      <= phase_onehot(phase);
        ram_wr_addr <= wr_ptr;
        phase       <= trigger ? '0 : phase + 1'b1;
        if (trigger) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  assign drain_end = (state == DRAIN) &&
                     (dcnt == DC_W'(DRAIN_N - 1));

  always_comb begin
    state_d = state;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (k == ADDR_W'(TAPS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          if (pending || trigger) begin
            state_d = RUN;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_d;
      if (start) begin
        k <= '0;
      end else if (state == RUN &&
                   k != ADDR_W'(TAPS - 1)) begin
        k <= k + 1'b1;
      end
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
    end
  end

  // A queued sweep uses the snapshot from its own trigger.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q    <= '0;
      base_pend <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start) begin
        base_q <= (state == DRAIN && pending) ?
                  base_pend : wr_ptr;
      end
      if (drain_end) begin
        if (pending) begin
          pending <= trigger;
          if (trigger) begin
            base_pend <= wr_ptr;
          end
        end
      end else if (trigger && state != IDLE) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending   <= 1'b1;
          base_pend <= wr_ptr;
        end
      end
    end
  end

  assign rom_addr    = k;
  assign ram_rd_addr = base_q - k;
  assign busy        = (state != IDLE);

  assign run_v     = (state == RUN);
  assign first_tap = run_v && (k == '0);
  assign last_tap  = run_v &&
                     (k == ADDR_W'(TAPS - 1));

  fir_seq_strobe_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_mac_dly (
    .clk   (clock),
    .rst_n (reset_n),
    .d     ({run_v, first_tap}),
    .q     ({mac_en, mac_clr})
  );

  fir_seq_strobe_delay #(
    .DEPTH (RD_LAT + MAC_LAT),
    .WIDTH (1)
  ) u_y_dly (
    .clk   (clock),
    .rst_n (reset_n),
    .d     (last_tap),
    .q     (y_avail)
  );

endmodule
